multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: N, default 32, operand/result width in bits (N >= 4, even).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  operation request; accepted only when busy=0.
REQ-005 SrcA, SrcB  input  N each  operands; captured on the accepting edge.
REQ-006 ALUControl  input  4  operation select; captured on the accepting edge.
REQ-007 ALUResult  output  N  registered result of the last completed operation.
REQ-008 Zero  output  1  registered; 1 when ALUResult == 0.
REQ-009 Overflow  output  1  registered signed overflow of ADD/SUB; 0 for all other ops.
REQ-010 DivByZero  output  1  registered; 1 when the last completed DIVU/REMU had SrcB == 0.
REQ-011 busy  output  1  1 while an iterative operation is in progress.
REQ-012 done  output  1  one-cycle completion pulse; result outputs are valid from this cycle onward.

Function
REQ-013 Encodings:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 SUB
- 0101 MUL (low N bits)
- 0110 SLT (signed)
- 0111 SLTU (unsigned)
- 1000 MULHU (high N bits of the unsigned product)
- 1001 DIVU (quotient)
- 1010 REMU (remainder)
- 1011-1111 undefined
REQ-014 States:
- IDLE and RUN.
- IDLE & start & iterative op (MUL, MULHU, DIVU with SrcB != 0, REMU with SrcB != 0) -> RUN.
- RUN with iteration counter = N-1 -> IDLE.
- All other IDLE cases remain in IDLE.
REQ-015 Single-cycle ops (AND, OR, ADD, XOR, SUB, SLT, SLTU, undefined, divide-by-zero): result and flags are written on the accepting edge; done=1 for exactly the following cycle.
REQ-016 Iterative ops:
- busy=1 for exactly N cycles after the accepting edge.
- Results and flags are written on the Nth edge; done=1 in the cycle after that edge, i.e. latency N+1 cycles from start to done.
REQ-017 MUL/MULHU: unsigned radix-2 shift-add over a 2N-bit product register, one operand bit per cycle.
REQ-018 DIVU/REMU: unsigned restoring division, one quotient bit per cycle; remainder < SrcB at completion.
REQ-019 Divide by zero: ALUResult = all ones (DIVU) or SrcA (REMU); DivByZero=1; single-cycle latency; no RUN entry.
REQ-020 Set-less-than ops: SLT/SLTU write 1 or 0 zero-extended to N bits.
REQ-021 Overflow rules: ADD overflow = operands same sign and result sign differs; SUB overflow = operands differ in sign and result sign differs from SrcA.
REQ-022 Undefined encodings: ALUResult=0, Zero=1, other flags 0, done after one cycle.
REQ-023 start while busy=1 is ignored: no capture, no effect on the running operation.
REQ-024 start in the same cycle as done=1 (busy=0) is accepted, giving back-to-back operation.
REQ-025 Outputs ALUResult/Zero/Overflow/DivByZero hold their values until the next completion; input changes after capture have no effect.
REQ-026 Operand or ALUControl changes during RUN have no effect on the result.
REQ-027 Flag update: DivByZero is cleared by any non-divide-by-zero completion; Overflow is cleared by any non-ADD/SUB completion.

Reset
REQ-028 reset=1 on an edge forces: state IDLE, iteration counter 0, busy=0, done=0, ALUResult=0, Zero=1, Overflow=0, DivByZero=0.
REQ-029 Reset during RUN aborts the operation: no done pulse and no partial result visible.
REQ-030 reset has priority over start in the same cycle; that start is discarded.

Verification (N=32)
REQ-031 ADD 0x7FFFFFFF + 0x00000001 -> ALUResult=0x80000000, Overflow=1, Zero=0, done 1 cycle after start, busy never 1.
REQ-032 MUL 0x00010000 * 0x00010000 -> ALUResult=0, Zero=1, busy=1 for 32 cycles, done on cycle 33; then MULHU with the same operands -> 0x00000001.
REQ-033 DIVU 100/7 -> 14; REMU 100/7 -> 2; start pulsed with ALUControl=ADD mid-RUN -> ignored, result unchanged, latency still 33.
REQ-034 DIVU 0x12345678/0 -> ALUResult=0xFFFFFFFF, DivByZero=1, done after 1 cycle; following REMU 5/0 -> 5, DivByZero=1; following ADD 1+1 -> 2, DivByZero=0.
REQ-035 SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU with the same operands -> 0; encoding 1111 -> ALUResult=0, Zero=1.
REQ-036 reset asserted on iteration 10 of DIVU -> busy=0, done stays 0, ALUResult=0, Zero=1; next ADD 3+4 -> 7 after 1 cycle.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide sharing one datapath.
module multicycle_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] SrcA,
  input  logic [N-1:0] SrcB,
  input  logic [3:0]   ALUControl,
  output logic [N-1:0] ALUResult,
  output logic         Zero,
  output logic         Overflow,
  output logic         DivByZero,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_MULHU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_REMU  = 4'b1010;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [N-1:0]  opd;

  logic [N-1:0]  sum_w;
  logic [N-1:0]  dif_w;
  logic [N-1:0]  res_c;
  logic          ovf_c;
  logic          dbz_c;
  logic          iter_c;
  logic          div_c;

  logic [N:0]    mul_sum;
  logic [N:0]    div_sh;
  logic [N-1:0]  div_dif;
  logic          div_ge;
  logic          is_div;
  logic [N-1:0]  hi_n;
  logic [N-1:0]  lo_n;
  logic [N-1:0]  fin_c;

  assign sum_w = SrcA + SrcB;
  assign dif_w = SrcA - SrcB;

  always_comb begin
    res_c  = '0;
    ovf_c  = 1'b0;
    dbz_c  = 1'b0;
    iter_c = 1'b0;
    div_c  = 1'b0;
    unique case (ALUControl)
      OP_AND:  res_c = SrcA & SrcB;
      OP_OR:   res_c = SrcA | SrcB;
      OP_XOR:  res_c = SrcA ^ SrcB;
      OP_ADD: begin
        res_c = sum_w;
        ovf_c = (SrcA[N-1] == SrcB[N-1]) &&
                (sum_w[N-1] != SrcA[N-1]);
      end
      OP_SUB: begin
        res_c = dif_w;
        ovf_c = (SrcA[N-1] != SrcB[N-1]) &&
                (dif_w[N-1] != SrcA[N-1]);
      end
      OP_SLT:
        res_c = {{(N-1){1'b0}},
                 $signed(SrcA) < $signed(SrcB)};
      OP_SLTU:
        res_c = {{(N-1){1'b0}}, SrcA < SrcB};
      OP_MUL, OP_MULHU:
        iter_c = 1'b1;
      OP_DIVU: begin
        div_c = 1'b1;
        if (SrcB == '0) begin
          res_c = '1;
          dbz_c = 1'b1;
        end else begin
          iter_c = 1'b1;
        end
      end
      OP_REMU: begin
        div_c = 1'b1;
        if (SrcB == '0) begin
          res_c = SrcA;
          dbz_c = 1'b1;
        end else begin
          iter_c = 1'b1;
        end
      end
      default: res_c = '0;
    endcase
  end

  // hi/lo is the 2N-bit product register for multiply and the
  // remainder/quotient pair for divide; opd is multiplicand/divisor.
  assign is_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign mul_sum = {1'b0, hi} +
                   (lo[0] ? {1'b0, opd} : {(N+1){1'b0}});
  assign div_sh  = {hi, lo[N-1]};
  assign div_ge  = div_sh >= {1'b0, opd};
  assign div_dif = div_sh[N-1:0] - opd;

  always_comb begin
    if (is_div) begin
      hi_n = div_ge ? div_dif : div_sh[N-1:0];
      lo_n = {lo[N-2:0], div_ge};
    end else begin
      hi_n = mul_sum[N:1];
      lo_n = {mul_sum[0], lo[N-1:1]};
    end
  end

  always_comb begin
    unique case (op_q)
      OP_MUL:   fin_c = lo_n;
      OP_DIVU:  fin_c = lo_n;
      OP_MULHU: fin_c = hi_n;
      default:  fin_c = hi_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      hi        <= '0;
      lo        <= '0;
      opd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (iter_c) begin
              state <= RUN;
              busy  <= 1'b1;
              cnt   <= '0;
              op_q  <= ALUControl;
              hi    <= '0;
              lo    <= div_c ? SrcA : SrcB;
              opd   <= div_c ? SrcB : SrcA;
            end else begin
              ALUResult <= res_c;
              Zero      <= (res_c == '0);
              Overflow  <= ovf_c;
              DivByZero <= dbz_c;
              done      <= 1'b1;
            end
          end
        end
        RUN: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N-1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cnt       <= '0;
            ALUResult <= fin_c;
            Zero      <= (fin_c == '0);
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at N=32 with
// hand-computed expected values.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  ctl;
  logic [31:0] res;
  logic        zero;
  logic        ovf;
  logic        dbz;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int lat;
  int bc;
  int seen;

  localparam logic [3:0] AND_  = 4'b0000;
  localparam logic [3:0] OR_   = 4'b0001;
  localparam logic [3:0] ADD_  = 4'b0010;
  localparam logic [3:0] XOR_  = 4'b0011;
  localparam logic [3:0] SUB_  = 4'b0100;
  localparam logic [3:0] MUL_  = 4'b0101;
  localparam logic [3:0] SLT_  = 4'b0110;
  localparam logic [3:0] SLTU_ = 4'b0111;
  localparam logic [3:0] MULH_ = 4'b1000;
  localparam logic [3:0] DIVU_ = 4'b1001;
  localparam logic [3:0] REMU_ = 4'b1010;

  multicycle_alu #(.N(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .SrcA(a),
    .SrcB(b),
    .ALUControl(ctl),
    .ALUResult(res),
    .Zero(zero),
    .Overflow(ovf),
    .DivByZero(dbz),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] c,
                    input logic [31:0] x,
                    input logic [31:0] y);
    ctl   = c;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle 1 after the accepting edge; returns the
  // start-to-done latency and number of busy cycles seen.
  task automatic waitdone(input int inj,
                          output int l,
                          output int bcount);
    l      = 1;
    bcount = busy ? 1 : 0;
    while (!done && l < 100) begin
      if (l == inj) begin
        start = 1'b1;
        ctl   = ADD_;
        a     = 32'h1111_1111;
        b     = 32'h2222_2222;
      end
      tick();
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      ctl   = 4'($urandom_range(0, 15));
      l++;
      if (busy) bcount++;
    end
  endtask

  task automatic single(input string tag,
                        input logic [3:0] c,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] e);
    go(c, x, y);
    chk({tag, "_res"}, res, e);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    ctl   = ADD_;
    a     = 32'd1;
    b     = 32'd1;
    tick();
    tick();
    chk("rst_res", res, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_start_drop", {31'd0, done}, 32'd0);

    single("add_ovf", ADD_, 32'h7FFF_FFFF, 32'h1,
           32'h8000_0000);
    chk("add_ovf_flag", {31'd0, ovf}, 32'd1);
    chk("add_ovf_zero", {31'd0, zero}, 32'd0);
    tick();
    chk("add_done_pulse", {31'd0, done}, 32'd0);
    chk("add_busy_after", {31'd0, busy}, 32'd0);

    go(MUL_, 32'h0001_0000, 32'h0001_0000);
    waitdone(-1, lat, bc);
    chk("mul_lat", lat, 33);
    chk("mul_busy", bc, 32);
    chk("mul_res", res, 32'd0);
    chk("mul_zero", {31'd0, zero}, 32'd1);
    chk("mul_ovf_clr", {31'd0, ovf}, 32'd0);
    go(MULH_, 32'h0001_0000, 32'h0001_0000);
    waitdone(-1, lat, bc);
    chk("mulhu_lat", lat, 33);
    chk("mulhu_res", res, 32'd1);
    chk("mulhu_zero", {31'd0, zero}, 32'd0);

    go(DIVU_, 32'd100, 32'd7);
    waitdone(5, lat, bc);
    chk("divu_lat", lat, 33);
    chk("divu_busy", bc, 32);
    chk("divu_res", res, 32'd14);
    tick();
    chk("divu_hold", res, 32'd14);
    go(REMU_, 32'd100, 32'd7);
    waitdone(12, lat, bc);
    chk("remu_lat", lat, 33);
    chk("remu_res", res, 32'd2);

    go(DIVU_, 32'hFFFF_FFFF, 32'h10);
    waitdone(-1, lat, bc);
    chk("divu_big", res, 32'h0FFF_FFFF);
    go(REMU_, 32'hFFFF_FFFF, 32'h10);
    waitdone(-1, lat, bc);
    chk("remu_big", res, 32'hF);
    go(MUL_, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitdone(-1, lat, bc);
    chk("mul_max", res, 32'h1);
    go(MULH_, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitdone(-1, lat, bc);
    chk("mulhu_max", res, 32'hFFFF_FFFE);

    single("div0", DIVU_, 32'h1234_5678, 32'd0,
           32'hFFFF_FFFF);
    chk("div0_dbz", {31'd0, dbz}, 32'd1);
    single("rem0", REMU_, 32'd5, 32'd0, 32'd5);
    chk("rem0_dbz", {31'd0, dbz}, 32'd1);
    single("add11", ADD_, 32'd1, 32'd1, 32'd2);
    chk("add11_dbz", {31'd0, dbz}, 32'd0);

    single("sub_ovf", SUB_, 32'h8000_0000, 32'd1,
           32'h7FFF_FFFF);
    chk("sub_ovf_flag", {31'd0, ovf}, 32'd1);
    single("sub_plain", SUB_, 32'd5, 32'd9,
           32'hFFFF_FFFC);
    chk("sub_plain_ovf", {31'd0, ovf}, 32'd0);
    single("and", AND_, 32'hF0F0_1234, 32'h0FF0_FF00,
           32'h00F0_1200);
    single("or", OR_, 32'hF000_0001, 32'h0000_0F10,
           32'hF000_0F11);
    single("xor", XOR_, 32'hAAAA_5555, 32'hFFFF_0000,
           32'h5555_5555);
    single("slt", SLT_, 32'hFFFF_FFFF, 32'd1, 32'd1);
    single("sltu", SLTU_, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("sltu_zero", {31'd0, zero}, 32'd1);
    single("undef", 4'b1111, 32'h1234, 32'h5678, 32'd0);
    chk("undef_zero", {31'd0, zero}, 32'd1);

    go(DIVU_, 32'd100, 32'd7);
    for (int i = 1; i < 10; i++) tick();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_res", res, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen++;
    end
    chk("abort_quiet", seen, 0);
    single("add34", ADD_, 32'd3, 32'd4, 32'd7);
    a   = 32'hDEAD_BEEF;
    b   = 32'h1;
    ctl = SUB_;
    tick();
    tick();
    chk("add34_hold", res, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
